// File: rtl/operand_recover.sv
// Recovers operand a = sum - b from a (W+1)-bit adder result, C bits per cycle.
// Define OPERAND_RECOVER_SAT_EN to clamp a on underflow/overflow instead of wrapping.
module operand_recover #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHUNK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   sum,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned C      = CHUNK_WIDTH;
    localparam int unsigned N      = W / C;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W:0]     sum_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   diff_q;
    logic [IDX_W-1:0] idx;
    logic           borrow;

    logic [C:0]     wide_c;
    logic [W-1:0]   res_c;
    logic           bout_c;
    logic           top_c;
    logic           underflow_c;
    logic           overflow_c;
    logic           err_c;
    logic [W-1:0]   a_next_c;

    // One chunk of the borrow-chained subtraction plus the final top-bit decode
    always_comb begin
        wide_c      = {1'b0, sum_q[idx*C +: C]} - {1'b0, b_q[idx*C +: C]} - (C+1)'(borrow);
        bout_c      = wide_c[C];
        res_c       = diff_q;
        res_c[idx*C +: C] = wide_c[C-1:0];
        top_c       = sum_q[W] ^ bout_c;
        underflow_c = ~sum_q[W] & bout_c;
        overflow_c  = top_c & ~underflow_c;
        err_c       = underflow_c | overflow_c;
`ifdef OPERAND_RECOVER_SAT_EN
        if (underflow_c)
            a_next_c = '0;
        else if (overflow_c)
            a_next_c = '1;
        else
            a_next_c = res_c;
`else
        a_next_c = res_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_q     <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            a         <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q    <= sum;
                        b_q      <= b;
                        idx      <= '0;
                        borrow   <= 1'b0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    diff_q <= res_c;
                    borrow <= bout_c;
                    idx    <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N - 1)) begin
                        a         <= a_next_c;
                        err       <= err_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // a/err keep the last result after the handshake
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_recover.sv
// Randomized self-checking bench for operand_recover (W=8, C=2) against an
// integer-arithmetic reference model; honours OPERAND_RECOVER_SAT_EN.
module tb_operand_recover;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sum;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic         err;
    logic         busy;

    int tests = 0;
    int fails = 0;

    operand_recover #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer difference, then wrap or clamp
    function automatic void model(input logic [W:0] s, input logic [W-1:0] bb,
                                  output logic [W-1:0] ea, output logic ee);
        int d;
        d  = int'(s) - int'(bb);
        ee = (d < 0) || (d > 255);
`ifdef OPERAND_RECOVER_SAT_EN
        if (d < 0)        ea = 8'h00;
        else if (d > 255) ea = 8'hFF;
        else              ea = W'(d);
`else
        ea = W'(d & 255);
`endif
    endfunction

    task automatic txn(input logic [W:0] s, input logic [W-1:0] bb,
                       input int hold, input bit noise);
        logic [W-1:0] ea;
        logic         ee;
        int           k;
        model(s, bb, ea, ee);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sum      = s;
        b        = bb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sum      = 9'($urandom);
        b        = 8'($urandom);
        check("in_ready_calc", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(LAT));
        check("a", 32'(a), 32'(ea));
        check("err", 32'(err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                sum      = 9'($urandom);
                b        = 8'($urandom);
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || a !== ea || err !== ee || in_ready !== 1'b0) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_a", 32'(a), 32'(ea));
                check("hold_err", 32'(err), 32'(ee));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        if (hold > 0) check("hold_stable_a", 32'(a), 32'(ea));
        check("busy_done", 32'(busy), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_clr", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("a_held", 32'(a), 32'(ea));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        txn(9'h0FF, 8'h0F, 0, 1'b0);
        txn(9'h1FE, 8'hFF, 1, 1'b0);
        txn(9'h005, 8'h07, 0, 1'b0);
        txn(9'h1FF, 8'h00, 2, 1'b0);
        txn(9'h0AA, 8'h55, 10, 1'b1);

        // Abort mid-calculation with asynchronous reset
        @(negedge clk);
        in_valid = 1'b1;
        sum      = 9'h1C3;
        b        = 8'h21;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_a", 32'(a), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(9'h064, 8'h14, 0, 1'b0);

        for (int t = 0; t < 40; t++)
            txn(9'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
